ext_pipe: RTL and testbench
===========================

Name: ext_pipe

Overview:
- Pipelined, parametrised immediate extender for the datapath's decode/execute boundary.
- Accepts an IMM_W-bit immediate plus a 2-bit extension opcode over a valid/ready handshake.
- Produces an OUT_W-bit extended result one cycle later.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
IMM_W, 16, immediate input width (>=2)
OUT_W, 32, result width (must be > IMM_W)
SHIFT, 2, left shift applied in mode 2'b11 (0..OUT_W-1)
CNT_W, 16, width of per-mode statistics counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept request this cycle
imm  input  IMM_W  immediate
EOp  input  2  extension mode
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
ext  output  OUT_W  extended result
stat_sel  input  2  selects mode counter for stat_cnt
stat_cnt  output  CNT_W  accepted-transaction count for mode stat_sel

Behaviour:
- Reset (rst_n=0, asynchronous): buffer emptied, out_valid=0, in_ready=1, ext=0, all counters=0. Reset mid-transfer drops every buffered entry; nothing is replayed after release.
- Accept: transfer in when in_valid && in_ready at a rising edge. Emit: transfer out when out_valid && out_ready.
- Extension function, computed on accept and stored:
  - 00 zero-extend imm to OUT_W.
  - 01 sign-extend from imm[IMM_W-1].
  - 10 load-upper: imm placed in ext[OUT_W-1:OUT_W-IMM_W], low bits 0.
  - 11 sign-extend, then shift left by SHIFT, truncated to OUT_W.
- Latency: a request accepted at edge N is visible on ext with out_valid=1 after edge N (same cycle window as N+1 sampling). There is no combinational path from imm/EOp to ext.
- Buffer FSM, states EMPTY, ONE, TWO:
  - EMPTY: in_ready=1, out_valid=0. Accept -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept and emit together -> ONE, head replaced by new entry.
    - Accept only -> TWO, new entry goes to the skid slot.
    - Emit only -> EMPTY.
    - Neither -> ONE.
  - TWO: in_ready=0, out_valid=1. Emit -> ONE, skid entry moves to head. in_valid is ignored in this state.
- in_ready is a register output: it deasserts the cycle after entering TWO and reasserts the cycle after leaving it.
- Ordering: strict FIFO. ext and the head entry hold stable while out_valid=1 and out_ready=0.
- Sustained in_valid=1 and out_ready=1 gives one result per cycle, with no bubbles after the first.

Optional Feature:
- Macro: EXT_PIPE_STATS_EN.
- Defined:
  - Four CNT_W-bit counters, one per EOp value, each incremented on every accept of that mode.
  - Counters saturate at all-ones.
  - stat_cnt = counter[stat_sel], combinational read.
  - Counters clear on reset only.
- Not defined: no counters are synthesised, stat_cnt is tied to 0, and stat_sel is ignored.

Test Plan (defaults IMM_W=16, OUT_W=32, SHIFT=2):
1. imm=16'h8001, EOp=00/01/10/11 back-to-back, out_ready=1 -> ext=32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004 on consecutive cycles, each one cycle after its accept.
2. imm=16'h7FFF, EOp=01 then 11 -> ext=32'h00007FFF, then 32'h0001FFFC.
3. Backpressure: out_ready=0, push 3 requests -> first 2 accepted. in_ready=0 from the cycle after the 2nd accept. The 3rd is held by the bench. Raise out_ready -> results emerge in order and the 3rd is accepted the cycle after in_ready returns to 1.
4. Simultaneous accept+emit in ONE for 8 cycles -> state stays ONE, 8 results in order, in_ready never drops.
5. Assert rst_n=0 asynchronously between edges while state=TWO -> out_valid=0, in_ready=1, ext=0 immediately. Nothing emitted after release.
6. With EXT_PIPE_STATS_EN: 3 accepts of mode 01 and 1 of mode 11 -> stat_cnt=3 for stat_sel=01, 1 for 11, 0 for 00. With CNT_W=2, 5 accepts of mode 00 saturate at 3. Without the macro, stat_cnt=0 throughout.

Source files
------------

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - pipelined immediate extender with 2-entry skid buffer
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (in_ready is registered)
//   imm, EOp             immediate and 2-bit extension mode
//   out_valid/out_ready  result handshake
//   ext                  registered extended result (head of buffer)
//   stat_sel, stat_cnt   per-mode accepted-transaction counter read port
//
// Optional macro EXT_PIPE_STATS_EN enables the per-mode statistics counters;
// without it stat_cnt is tied to 0 and stat_sel is ignored.
`timescale 1ns/1ps
module ext_pipe #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] imm,
  input  logic [1:0]       EOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext,
  input  logic [1:0]       stat_sel,
  output logic [CNT_W-1:0] stat_cnt
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_in_ready;
  logic [OUT_W-1:0] r_head;
  logic [OUT_W-1:0] r_skid;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext_new;
  logic             w_accept;
  logic             w_emit;
  logic             w_load_head_new;
  logic             w_load_head_skid;
  logic             w_load_skid;

  assign w_accept  = in_valid && r_in_ready;
  assign w_emit    = out_valid && out_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != S_EMPTY);
  assign ext       = r_head;

  assign w_sext = {{(OUT_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    w_ext_new = '0;
    case (EOp)
      2'b00:   w_ext_new = {{(OUT_W-IMM_W){1'b0}}, imm};
      2'b01:   w_ext_new = w_sext;
      2'b10:   w_ext_new = {imm, {(OUT_W-IMM_W){1'b0}}};
      default: w_ext_new = w_sext << SHIFT;
    endcase
  end

  always_comb begin
    w_next_state     = r_state;
    w_load_head_new  = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_next_state    = S_ONE;
          w_load_head_new = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_emit) begin
          w_load_head_new = 1'b1;
        end else if (w_accept) begin
          w_next_state = S_TWO;
          w_load_skid  = 1'b1;
        end else if (w_emit) begin
          w_next_state = S_EMPTY;
        end
      end
      S_TWO: begin
        // in_ready is low here, so w_accept cannot fire; only draining matters.
        if (w_emit) begin
          w_next_state     = S_ONE;
          w_load_head_skid = 1'b1;
        end
      end
      default: w_next_state = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_skid     <= '0;
    end else begin
      r_state <= w_next_state;
      // Registered ready: low exactly while the buffer holds two entries.
      r_in_ready <= (w_next_state != S_TWO);
      if (w_load_head_new) begin
        r_head <= w_ext_new;
      end else if (w_load_head_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_ext_new;
      end
    end
  end

`ifdef EXT_PIPE_STATS_EN
  logic [CNT_W-1:0] r_cnt [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_accept && !(&r_cnt[EOp])) begin
      r_cnt[EOp] <= r_cnt[EOp] + CNT_W'(1);
    end
  end

  assign stat_cnt = r_cnt[stat_sel];
`else
  logic w_unused_stat_sel;
  assign w_unused_stat_sel = ^stat_sel;
  assign stat_cnt          = '0;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - directed self-checking bench for ext_pipe
`timescale 1ns/1ps
module tb_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] imm;
  logic [1:0]  EOp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ext;
  logic [1:0]  stat_sel;
  logic [15:0] stat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  ext_pipe #(.IMM_W(16), .OUT_W(32), .SHIFT(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .EOp(EOp), .out_valid(out_valid), .out_ready(out_ready),
    .ext(ext), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

`ifdef EXT_PIPE_STATS_EN
  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [31:0] sat_ext;
  logic [1:0] sat_cnt;

  ext_pipe #(.IMM_W(16), .OUT_W(32), .SHIFT(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .imm(imm), .EOp(EOp), .out_valid(sat_out_valid), .out_ready(out_ready),
    .ext(sat_ext), .stat_sel(stat_sel), .stat_cnt(sat_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    imm       = '0;
    EOp       = 2'b00;
    out_ready = 1'b0;
    stat_sel  = 2'b00;
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_ext",       ext,                32'h0);
    chk("rst_stat",      {16'b0, stat_cnt},  32'h0);
    rst_n = 1'b1;
    tick();

    // Test 1: four modes back-to-back on 16'h8001
    out_ready = 1'b1;
    in_valid  = 1'b1;
    imm       = 16'h8001;
    EOp       = 2'b00;
    tick();
    chk("t1_valid0", {31'b0, out_valid}, 32'd1);
    chk("t1_zext",   ext, 32'h00008001);
    EOp = 2'b01;
    tick();
    chk("t1_sext",   ext, 32'hFFFF8001);
    EOp = 2'b10;
    tick();
    chk("t1_upper",  ext, 32'h80010000);
    EOp = 2'b11;
    tick();
    chk("t1_shift",  ext, 32'hFFFE0004);
    chk("t1_ready",  {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("t1_drain",  {31'b0, out_valid}, 32'd0);

    // Test 2: positive immediate
    in_valid = 1'b1;
    imm      = 16'h7FFF;
    EOp      = 2'b01;
    tick();
    chk("t2_sext",  ext, 32'h00007FFF);
    EOp = 2'b11;
    tick();
    chk("t2_shift", ext, 32'h0001FFFC);
    in_valid = 1'b0;
    tick();

    // Test 3: backpressure fills the skid slot
    out_ready = 1'b0;
    in_valid  = 1'b1;
    EOp       = 2'b00;
    imm       = 16'h0001;
    tick();
    chk("t3_ready_one", {31'b0, in_ready}, 32'd1);
    chk("t3_head1",     ext, 32'h1);
    imm = 16'h0002;
    tick();
    chk("t3_ready_two", {31'b0, in_ready}, 32'd0);
    chk("t3_hold1",     ext, 32'h1);
    imm = 16'h0003;
    tick();
    chk("t3_stall_rdy", {31'b0, in_ready}, 32'd0);
    chk("t3_stall_ext", ext, 32'h1);
    chk("t3_stall_vld", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t3_head2",     ext, 32'h2);
    chk("t3_ready_back", {31'b0, in_ready}, 32'd1);
    tick();
    chk("t3_head3",     ext, 32'h3);
    in_valid = 1'b0;
    tick();
    chk("t3_empty",     {31'b0, out_valid}, 32'd0);

    // Test 4: sustained accept+emit in ONE
    in_valid = 1'b1;
    imm      = 16'h0010;
    tick();
    for (int i = 1; i <= 8; i++) begin
      imm = 16'(16'h0010 + i);
      tick();
      chk("t4_ext",   ext, 32'h10 + 32'(i));
      chk("t4_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("t4_empty", {31'b0, out_valid}, 32'd0);

    // Test 5: asynchronous reset while holding two entries
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm       = 16'h00AA;
    tick();
    imm = 16'h00BB;
    tick();
    chk("t5_in_two", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_rst_ready", {31'b0, in_ready},  32'd1);
    chk("t5_rst_ext",   ext, 32'h0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_replay", {31'b0, out_valid}, 32'd0);
    end

    // Test 6: statistics
    in_valid = 1'b1;
    imm      = 16'h1234;
    EOp      = 2'b01;
    tick();
    tick();
    tick();
    EOp = 2'b11;
    tick();
    EOp = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    tick();
`ifdef EXT_PIPE_STATS_EN
    stat_sel = 2'b01;
    #1;
    chk("t6_cnt01", {16'b0, stat_cnt}, 32'd3);
    stat_sel = 2'b11;
    #1;
    chk("t6_cnt11", {16'b0, stat_cnt}, 32'd1);
    stat_sel = 2'b10;
    #1;
    chk("t6_cnt10", {16'b0, stat_cnt}, 32'd0);
    stat_sel = 2'b00;
    #1;
    chk("t6_cnt00", {16'b0, stat_cnt}, 32'd5);
    chk("t6_sat00", {30'b0, sat_cnt},  32'd3);
`else
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
      chk("t6_stat_off", {16'b0, stat_cnt}, 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
